fifo_tx_drain: RTL and testbench

- Downstream consumer of the packet FIFO SRAM.
- Pops 72-bit words (ctrl[71:64] + data[63:0]) through the FIFO read strobe and absorbs the 1-cycle SRAM read latency in a 2-entry output buffer.
- Presents words on a valid/ready-style output port (out_wr/out_rdy) towards the MAC/output queue.
- Tracks packet framing, gates packet starts with tx_enable, and counts transmitted packets.

---
 rtl/fifo_tx_drain.sv | 186 ++++++++++++++++++
 tb/tb_fifo_tx_drain.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_tx_drain.sv
// fifo_tx_drain: pops words from the packet FIFO SRAM, hides its one-cycle
// read latency behind a two-entry buffer, and hands packets to the MAC side
// on a valid/ready port while tracking framing, length and packet count.
module fifo_tx_drain #(
  parameter int DWIDTH    = 72,
  parameter int CWIDTH    = 8,
  parameter int CNT_WIDTH = 16,
  parameter int MAX_WORDS = 192
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     tx_enable,
  input  logic                     fifo_empty,
  input  logic [DWIDTH-1:0]        fifo_output,
  output logic                     fifo_reb,
  output logic [DWIDTH-CWIDTH-1:0] out_data,
  output logic [CWIDTH-1:0]        out_ctrl,
  output logic                     out_wr,
  input  logic                     out_rdy,
  output logic                     busy,
  output logic [CNT_WIDTH-1:0]     pkt_count,
  output logic                     err_len
);

  localparam int DW = DWIDTH - CWIDTH;
  localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    BODY = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [DWIDTH-1:0]     buf0_q, buf0_d;   // buffer head
  logic [DWIDTH-1:0]     buf1_q, buf1_d;   // buffer tail (second entry)
  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q;
  logic [CNT_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic [CNT_WIDTH-1:0]  pkt_count_q, pkt_count_d;
  logic                  err_q, err_d;

  logic                  head_vld;
  logic                  head_is_ctrl;
  logic                  pop_c;
  logic                  out_wr_c;
  logic                  pkt_done_c;
  logic                  err_set_c;
  logic [2:0]            used_c;

  assign head_vld     = (occ_q != 2'd0);
  assign head_is_ctrl = |buf0_q[DWIDTH-1 -: CWIDTH];

  // Slots still claimed next cycle: the head leaving this cycle frees its
  // slot immediately, so a steady stream keeps one read in flight per cycle.
  always_comb begin
    used_c = 3'(occ_q) + 3'(inflight_q) - 3'(pop_c);
  end

  assign fifo_reb  = reset_n && !fifo_empty && (used_c < 3'd2);
  assign out_wr    = out_wr_c;
  assign out_data  = buf0_q[DW-1:0];
  assign out_ctrl  = buf0_q[DWIDTH-1 -: CWIDTH];
  assign busy      = (state_q != IDLE) || head_vld || inflight_q;
  assign pkt_count = pkt_count_q;
  assign err_len   = err_q;

  // Framing FSM: decides whether the head word is presented, dropped or held.
  always_comb begin
    state_d    = state_q;
    out_wr_c   = 1'b0;
    pop_c      = 1'b0;
    wcnt_d     = wcnt_q;
    pkt_done_c = 1'b0;
    err_set_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (head_vld) begin
          if (!head_is_ctrl) begin
            // stray body word outside a packet: discard silently
            pop_c = 1'b1;
          end else if (tx_enable) begin
            out_wr_c = 1'b1;
            if (out_rdy) begin
              pop_c   = 1'b1;
              wcnt_d  = CNT_WIDTH'(1);
              state_d = HDR;
            end
          end
        end
      end
      HDR: begin
        if (head_vld) begin
          out_wr_c = 1'b1;
          if (out_rdy) begin
            pop_c   = 1'b1;
            wcnt_d  = wcnt_q + CNT_WIDTH'(1);
            state_d = head_is_ctrl ? HDR : BODY;
            if (wcnt_d == MAX_CNT) begin
              err_set_c = 1'b1;
              state_d   = DROP;
            end
          end
        end
      end
      BODY: begin
        if (head_vld) begin
          out_wr_c = 1'b1;
          if (out_rdy) begin
            pop_c  = 1'b1;
            wcnt_d = wcnt_q + CNT_WIDTH'(1);
            if (head_is_ctrl) begin
              pkt_done_c = 1'b1;
              state_d    = IDLE;
            end else if (wcnt_d == MAX_CNT) begin
              err_set_c = 1'b1;
              state_d   = DROP;
            end
          end
        end
      end
      DROP: begin
        // over-length packet: swallow the rest up to and including its EOP
        if (head_vld) begin
          pop_c = 1'b1;
          if (head_is_ctrl) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output buffer next state: push the returning SRAM word, pop the head.
  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    occ_d  = occ_q;
    case ({inflight_q, pop_c})
      2'b10: begin
        if (occ_q == 2'd0) buf0_d = fifo_output;
        else               buf1_d = fifo_output;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        if (occ_q == 2'd1) begin
          buf0_d = fifo_output;
        end else begin
          buf0_d = buf1_q;
          buf1_d = fifo_output;
        end
      end
      default: ;
    endcase
    pkt_count_d = pkt_count_q + (pkt_done_c ? CNT_WIDTH'(1) : CNT_WIDTH'(0));
    err_d       = err_q | err_set_c;
  end

  // State, buffer and counter registers; reset drops anything buffered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      buf0_q      <= '0;
      buf1_q      <= '0;
      occ_q       <= 2'd0;
      inflight_q  <= 1'b0;
      wcnt_q      <= '0;
      pkt_count_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      occ_q       <= occ_d;
      inflight_q  <= fifo_reb;
      wcnt_q      <= wcnt_d;
      pkt_count_q <= pkt_count_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_fifo_tx_drain.sv
// Directed bench for fifo_tx_drain with a behavioural FIFO SRAM model.
module tb_fifo_tx_drain;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        tx_enable;
  logic        fifo_empty;
  logic [71:0] fifo_output;
  logic        fifo_reb;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic        busy;
  logic [15:0] pkt_count;
  logic        err_len;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_tx_drain #(
    .DWIDTH(72), .CWIDTH(8), .CNT_WIDTH(16), .MAX_WORDS(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tx_enable(tx_enable),
    .fifo_empty(fifo_empty), .fifo_output(fifo_output), .fifo_reb(fifo_reb),
    .out_data(out_data), .out_ctrl(out_ctrl), .out_wr(out_wr),
    .out_rdy(out_rdy), .busy(busy), .pkt_count(pkt_count), .err_len(err_len)
  );

  // FIFO SRAM model: one-cycle read latency, flushed by system reset
  logic [71:0] fmem [0:63];
  logic [5:0]  wr_ptr = '0;
  logic [5:0]  rd_ptr;
  assign fifo_empty = (rd_ptr == wr_ptr);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr      <= wr_ptr;
      fifo_output <= '0;
    end else if (fifo_reb) begin
      fifo_output <= fmem[rd_ptr];
      rd_ptr      <= rd_ptr + 6'd1;
    end
  end

  // Transfer monitor
  int          cyc   = 0;
  int          rx_n  = 0;
  int          reb_n = 0;
  logic [71:0] rx_mem [0:63];
  int          rx_cyc [0:63];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_wr && out_rdy) begin
      rx_mem[rx_n[5:0]] <= {out_ctrl, out_data};
      rx_cyc[rx_n[5:0]] <= cyc;
      rx_n <= rx_n + 1;
    end
    if (fifo_reb) reb_n <= reb_n + 1;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic push(input logic [7:0] c, input logic [63:0] d);
    fmem[wr_ptr] = {c, d};
    wr_ptr = wr_ptr + 6'd1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; tx_enable = 1'b1; out_rdy = 1'b1;
    #12;
    n_cmp++;
    if ({fifo_reb, out_wr, busy, err_len} !== 4'b0000) begin
      $display("FAIL reset_ctl: got %b expected 0000", {fifo_reb, out_wr, busy, err_len}); n_fail++;
    end
    n_cmp++;
    if (out_data !== 64'd0) begin
      $display("FAIL reset_data: got %h expected 0", out_data); n_fail++;
    end
    n_cmp++;
    if (out_ctrl !== 8'd0) begin
      $display("FAIL reset_ctrl: got %h expected 0", out_ctrl); n_fail++;
    end
    n_cmp++;
    if (pkt_count !== 16'd0) begin
      $display("FAIL reset_pkt: got %0d expected 0", pkt_count); n_fail++;
    end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_pkt();
    logic [71:0] exp [0:2];
    logic [5:0]  rt, wt;
    int r0, bad;
    r0 = rx_n;
    exp[0] = {8'hFF, 64'h1111_0000_0000_0001};
    exp[1] = {8'h00, 64'h1111_0000_0000_0002};
    exp[2] = {8'h0F, 64'h1111_0000_0000_0003};
    for (int k = 0; k < 3; k++) push(exp[k][71:64], exp[k][63:0]);
    for (int i = 0; i < 6; i++) begin
      smp();
      rt[i] = fifo_reb;
      wt[i] = out_wr;
    end
    n_cmp++;
    if (rt !== 6'b000111) begin
      $display("FAIL single_reb_trace: got %b expected 000111", rt); n_fail++;
    end
    n_cmp++;
    if (wt !== 6'b011100) begin
      $display("FAIL single_wr_trace: got %b expected 011100", wt); n_fail++;
    end
    n_cmp++;
    if (pkt_count !== 16'd1 || busy !== 1'b0) begin
      $display("FAIL single_done: got pkt=%0d busy=%b expected pkt=1 busy=0", pkt_count, busy); n_fail++;
    end
    bad = 0;
    for (int k = 0; k < 3; k++) if (rx_mem[6'(r0 + k)] !== exp[k]) bad++;
    n_cmp++;
    if (rx_n - r0 != 3 || bad != 0) begin
      $display("FAIL single_words: got %0d words %0d wrong expected 3 words 0 wrong", rx_n - r0, bad); n_fail++;
    end
    tick();
  endtask

  task automatic test_stall();
    logic [71:0] exp [0:3];
    int r0, bad, rebs, found;
    logic [15:0] pc0;
    r0 = rx_n; pc0 = pkt_count;
    exp[0] = {8'hFF, 64'h2222_0000_0000_0001};
    exp[1] = {8'h00, 64'h2222_0000_0000_0002};
    exp[2] = {8'h00, 64'h2222_0000_0000_0003};
    exp[3] = {8'h0F, 64'h2222_0000_0000_0004};
    for (int k = 0; k < 4; k++) push(exp[k][71:64], exp[k][63:0]);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      smp();
      if (out_wr && out_rdy) found = 1;
    end
    n_cmp++;
    if (found == 0) begin
      $display("FAIL stall_first_word: got timeout expected transfer"); n_fail++;
    end
    tick();
    out_rdy = 1'b0;
    bad = 0; rebs = 0;
    for (int i = 0; i < 5; i++) begin
      smp();
      if (out_wr !== 1'b1 || {out_ctrl, out_data} !== exp[1]) bad++;
      if (fifo_reb) rebs++;
    end
    n_cmp++;
    if (bad != 0) begin
      $display("FAIL stall_hold: got %0d unstable cycles expected 0", bad); n_fail++;
    end
    n_cmp++;
    if (rebs != 0) begin
      $display("FAIL stall_reb: got %0d reads expected 0", rebs); n_fail++;
    end
    tick();
    out_rdy = 1'b1;
    for (int i = 0; i < 20 && pkt_count !== pc0 + 16'd1; i++) smp();
    n_cmp++;
    if (pkt_count !== pc0 + 16'd1) begin
      $display("FAIL stall_pkt: got %0d expected %0d", pkt_count, pc0 + 16'd1); n_fail++;
    end
    bad = 0;
    for (int k = 0; k < 4; k++) if (rx_mem[6'(r0 + k)] !== exp[k]) bad++;
    n_cmp++;
    if (rx_n - r0 != 4 || bad != 0) begin
      $display("FAIL stall_words: got %0d words %0d wrong expected 4 words 0 wrong", rx_n - r0, bad); n_fail++;
    end
    n_cmp++;
    if (err_len !== 1'b0) begin
      $display("FAIL maxlen_ok: got err_len=%b expected 0", err_len); n_fail++;
    end
    tick();
  endtask

  task automatic test_tx_enable();
    logic [71:0] exp [0:5];
    int r0, b0, bad;
    logic [15:0] pc0;
    r0 = rx_n; b0 = reb_n; pc0 = pkt_count;
    exp[0] = {8'hFF, 64'h3333_0000_0000_0001};
    exp[1] = {8'h00, 64'h3333_0000_0000_0002};
    exp[2] = {8'h0F, 64'h3333_0000_0000_0003};
    exp[3] = {8'hF0, 64'h3333_0000_0000_0004};
    exp[4] = {8'h00, 64'h3333_0000_0000_0005};
    exp[5] = {8'h03, 64'h3333_0000_0000_0006};
    tx_enable = 1'b0;
    for (int k = 0; k < 6; k++) push(exp[k][71:64], exp[k][63:0]);
    for (int i = 0; i < 6; i++) smp();
    n_cmp++;
    if ({out_wr, fifo_reb, busy} !== 3'b001 || rx_n != r0) begin
      $display("FAIL txen_hold: got wr/reb/busy=%b rx=%0d expected 001 rx=0", {out_wr, fifo_reb, busy}, rx_n - r0); n_fail++;
    end
    n_cmp++;
    if (reb_n - b0 != 2) begin
      $display("FAIL txen_fill: got %0d reads expected 2", reb_n - b0); n_fail++;
    end
    tick();
    tx_enable = 1'b1;
    for (int i = 0; i < 30 && pkt_count !== pc0 + 16'd2; i++) smp();
    n_cmp++;
    if (pkt_count !== pc0 + 16'd2) begin
      $display("FAIL txen_pkt: got %0d expected %0d", pkt_count, pc0 + 16'd2); n_fail++;
    end
    bad = 0;
    for (int k = 0; k < 6; k++) if (rx_mem[6'(r0 + k)] !== exp[k]) bad++;
    n_cmp++;
    if (rx_n - r0 != 6 || bad != 0) begin
      $display("FAIL txen_words: got %0d words %0d wrong expected 6 words 0 wrong", rx_n - r0, bad); n_fail++;
    end
    n_cmp++;
    if (rx_cyc[6'(r0 + 5)] - rx_cyc[6'(r0)] != 5) begin
      $display("FAIL back_to_back: got span %0d expected 5", rx_cyc[6'(r0 + 5)] - rx_cyc[6'(r0)]); n_fail++;
    end
    tick();
  endtask

  task automatic test_stray();
    logic [71:0] exp [0:2];
    int r0, b0, bad;
    logic [15:0] pc0;
    r0 = rx_n; b0 = reb_n; pc0 = pkt_count;
    exp[0] = {8'hC0, 64'h4444_0000_0000_0001};
    exp[1] = {8'h00, 64'h4444_0000_0000_0002};
    exp[2] = {8'h05, 64'h4444_0000_0000_0003};
    push(8'h00, 64'hDEAD_BEEF_0000_0000);
    for (int k = 0; k < 3; k++) push(exp[k][71:64], exp[k][63:0]);
    for (int i = 0; i < 20 && pkt_count !== pc0 + 16'd1; i++) smp();
    smp();
    n_cmp++;
    if (reb_n - b0 != 4) begin
      $display("FAIL stray_pop: got %0d reads expected 4", reb_n - b0); n_fail++;
    end
    bad = 0;
    for (int k = 0; k < 3; k++) if (rx_mem[6'(r0 + k)] !== exp[k]) bad++;
    n_cmp++;
    if (rx_n - r0 != 3 || bad != 0 || pkt_count !== pc0 + 16'd1) begin
      $display("FAIL stray_pkt: got %0d words %0d wrong pkt=%0d expected 3 words 0 wrong pkt=%0d", rx_n - r0, bad, pkt_count, pc0 + 16'd1); n_fail++;
    end
    tick();
  endtask

  task automatic test_len_err();
    logic [71:0] w [0:8];
    int r0, bad;
    logic [15:0] pc0;
    r0 = rx_n; pc0 = pkt_count;
    w[0] = {8'hFF, 64'h5555_0000_0000_0001};
    for (int k = 1; k < 5; k++) w[k] = {8'h00, 64'h5555_0000_0000_0001 + 64'(k)};
    w[5] = {8'h0F, 64'h5555_0000_0000_0006};
    w[6] = {8'hAA, 64'h6666_0000_0000_0001};
    w[7] = {8'h00, 64'h6666_0000_0000_0002};
    w[8] = {8'h01, 64'h6666_0000_0000_0003};
    for (int k = 0; k < 9; k++) push(w[k][71:64], w[k][63:0]);
    for (int i = 0; i < 40 && pkt_count !== pc0 + 16'd1; i++) smp();
    for (int i = 0; i < 3; i++) smp();
    n_cmp++;
    if (err_len !== 1'b1) begin
      $display("FAIL len_err_flag: got %b expected 1", err_len); n_fail++;
    end
    n_cmp++;
    if (pkt_count !== pc0 + 16'd1) begin
      $display("FAIL len_err_pkt: got %0d expected %0d", pkt_count, pc0 + 16'd1); n_fail++;
    end
    bad = 0;
    for (int k = 0; k < 4; k++) if (rx_mem[6'(r0 + k)] !== w[k]) bad++;
    for (int k = 0; k < 3; k++) if (rx_mem[6'(r0 + 4 + k)] !== w[6 + k]) bad++;
    n_cmp++;
    if (rx_n - r0 != 7 || bad != 0) begin
      $display("FAIL len_err_words: got %0d words %0d wrong expected 7 words 0 wrong", rx_n - r0, bad); n_fail++;
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [71:0] exp [0:2];
    int found, r0, bad, seen;
    push(8'hFF, 64'h7777_0000_0000_0001);
    push(8'h00, 64'h7777_0000_0000_0002);
    push(8'h0F, 64'h7777_0000_0000_0003);
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      smp();
      if (out_wr && out_rdy) found = 1;
    end
    tick();
    out_rdy = 1'b0;
    smp();
    n_cmp++;
    if (out_wr !== 1'b1 || found == 0) begin
      $display("FAIL rstmid_setup: got out_wr=%b expected 1", out_wr); n_fail++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({fifo_reb, out_wr, busy, err_len} !== 4'b0000 || out_data !== 64'd0 ||
        out_ctrl !== 8'd0 || pkt_count !== 16'd0) begin
      $display("FAIL rstmid_async: got ctl=%b data=%h ctrl=%h pkt=%0d expected all zero",
               {fifo_reb, out_wr, busy, err_len}, out_data, out_ctrl, pkt_count); n_fail++;
    end
    tick(); tick();
    reset_n = 1'b1;
    out_rdy = 1'b1;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      smp();
      if (out_wr) seen++;
    end
    n_cmp++;
    if (seen != 0 || busy !== 1'b0 || pkt_count !== 16'd0) begin
      $display("FAIL rstmid_after: got wr_cycles=%0d busy=%b pkt=%0d expected 0 0 0", seen, busy, pkt_count); n_fail++;
    end
    tick();
    r0 = rx_n;
    exp[0] = {8'h81, 64'h8888_0000_0000_0001};
    exp[1] = {8'h00, 64'h8888_0000_0000_0002};
    exp[2] = {8'hFF, 64'h8888_0000_0000_0003};
    for (int k = 0; k < 3; k++) push(exp[k][71:64], exp[k][63:0]);
    for (int i = 0; i < 20 && pkt_count !== 16'd1; i++) smp();
    bad = 0;
    for (int k = 0; k < 3; k++) if (rx_mem[6'(r0 + k)] !== exp[k]) bad++;
    n_cmp++;
    if (pkt_count !== 16'd1 || rx_n - r0 != 3 || bad != 0) begin
      $display("FAIL rstmid_next: got pkt=%0d words=%0d wrong=%0d expected 1 3 0", pkt_count, rx_n - r0, bad); n_fail++;
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_pkt();
    test_stall();
    test_tx_enable();
    test_stray();
    test_len_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
